core_boot_ctrl: RTL and testbench

Parametrised power-on sequencer for the RISC-V core cluster. After reset it performs these steps in order:
- programs every slot base address;
- releases each core through a single-beat AXI write to that core's control word, waiting for and checking the B response;
- preloads the RX descriptor pool with every core/slot pair under full valid/ready flow control;
- enables the RX/TX chains.
It sits between the PCIe-side AXI master port of the interconnect and the scheduler. A software-triggered re-initialisation is supported.

---
 rtl/core_boot_pkg.sv | 25 ++
 rtl/core_boot_axi_wr.sv | 77 +++++++
 rtl/core_boot_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_core_boot_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_boot_pkg.sv
// Shared types and constants for the core cluster boot sequencer.
// The optional B-response timeout is enabled with `define CORE_BOOT_TIMEOUT_EN.
package core_boot_pkg;

  typedef enum logic [2:0] {
    WAIT_DLY,
    SLOT_PROG,
    CORE_WR,
    CORE_RESP,
    DESC_INJ,
    RUN,
    ERROR
  } boot_state_t;

  localparam logic [1:0] OKAY       = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // Widest strobe the helper can describe; callers slice to their own width.
  localparam int unsigned MAX_STRB = 128;

  function automatic logic [MAX_STRB-1:0] top_lane_strb(input int unsigned strb_width);
    top_lane_strb = MAX_STRB'(1) << (strb_width - 1);
  endfunction

endpackage

// File: rtl/core_boot_axi_wr.sv
// Single-beat AXI write engine: issues AW and W together, lets each drop on its
// own ready, then collects the B response (bready is tied high by the parent).
module core_boot_axi_wr
  import core_boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic                  busy,
  output logic                  issued,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid
);

  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  bwait_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [STRB_WIDTH-1:0] strb_reg;
  logic                  aw_fin;
  logic                  w_fin;

  // A channel counts as finished when it is idle or handshaking this cycle.
  assign aw_fin = !awvalid_reg || m_axi_awready;
  assign w_fin  = !wvalid_reg || m_axi_wready;
  assign issued = (awvalid_reg || wvalid_reg) && aw_fin && w_fin;
  assign done   = bwait_reg && m_axi_bvalid;
  assign err    = done && (m_axi_bresp != OKAY);
  assign busy   = awvalid_reg || wvalid_reg || bwait_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bwait_reg   <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      strb_reg    <= '0;
    end else if (start) begin
      awvalid_reg <= 1'b1;
      wvalid_reg  <= 1'b1;
      bwait_reg   <= 1'b0;
      addr_reg    <= addr;
      data_reg    <= data;
      strb_reg    <= strb;
    end else begin
      if (awvalid_reg && m_axi_awready) awvalid_reg <= 1'b0;
      if (wvalid_reg && m_axi_wready)   wvalid_reg  <= 1'b0;
      if (issued)    bwait_reg <= 1'b1;
      else if (done) bwait_reg <= 1'b0;
    end
  end

  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = data_reg;
  assign m_axi_wstrb   = strb_reg;
  assign m_axi_wvalid  = wvalid_reg;

endmodule

// File: rtl/core_boot_ctrl.sv
// Power-on sequencer for the RISC-V cluster: slot programming, per-core release
// writes, RX descriptor preload, chain enable. Option: CORE_BOOT_TIMEOUT_EN.
module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 19,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned RISCV_CORES     = 8,
  parameter int unsigned RISCV_SLOTS     = 16,
  parameter int unsigned SLOT_ADDR_EFF   = 7,
  parameter logic [SLOT_ADDR_EFF-1:0] FIRST_SLOT_ADDR = 7'h40,
  parameter logic [SLOT_ADDR_EFF-1:0] SLOT_ADDR_STEP  = 7'h04,
  parameter int unsigned CORE_ADDR_LSB   = 16,
  parameter logic [ADDR_WIDTH-1:0] CTRL_OFFSET = 'hFFF8,
  parameter logic [7:0]  CTRL_BYTE       = 8'h00,
  parameter int unsigned START_DELAY     = 1000,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned CORE_NO_WIDTH   = $clog2(RISCV_CORES),
  parameter int unsigned SLOT_NO_WIDTH   = $clog2(RISCV_SLOTS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   init_req,
  output logic [ID_WIDTH-1:0]                    m_axi_awid,
  output logic [ADDR_WIDTH-1:0]                  m_axi_awaddr,
  output logic [7:0]                             m_axi_awlen,
  output logic [2:0]                             m_axi_awsize,
  output logic [1:0]                             m_axi_awburst,
  output logic                                   m_axi_awvalid,
  input  logic                                   m_axi_awready,
  output logic [DATA_WIDTH-1:0]                  m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                m_axi_wstrb,
  output logic                                   m_axi_wlast,
  output logic                                   m_axi_wvalid,
  input  logic                                   m_axi_wready,
  input  logic [ID_WIDTH-1:0]                    m_axi_bid,
  input  logic [1:0]                             m_axi_bresp,
  input  logic                                   m_axi_bvalid,
  output logic                                   m_axi_bready,
  output logic [SLOT_NO_WIDTH-1:0]               slot_addr_wr_no,
  output logic [SLOT_ADDR_EFF-1:0]               slot_addr_wr_data,
  output logic                                   slot_addr_wr_valid,
  output logic [CORE_NO_WIDTH+SLOT_NO_WIDTH-1:0] inject_rx_desc,
  output logic                                   inject_rx_desc_valid,
  input  logic                                   inject_rx_desc_ready,
  output logic                                   tx_enable,
  output logic                                   rx_enable,
  output logic                                   rx_abort,
  output logic                                   init_done,
  output logic                                   init_error,
  output logic [CORE_NO_WIDTH-1:0]               err_core
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DLY_W      = $clog2(START_DELAY + 1);
  localparam logic [DLY_W-1:0]         LAST_DLY  = DLY_W'(START_DELAY - 1);
  localparam logic [CORE_NO_WIDTH-1:0] LAST_CORE = CORE_NO_WIDTH'(RISCV_CORES - 1);
  localparam logic [SLOT_NO_WIDTH-1:0] LAST_SLOT = SLOT_NO_WIDTH'(RISCV_SLOTS - 1);
  localparam logic [MAX_STRB-1:0]      STRB_ALL  = top_lane_strb(STRB_WIDTH);

  boot_state_t              state_reg, state_next;
  logic [DLY_W-1:0]         dly_reg, dly_next;
  logic [SLOT_NO_WIDTH-1:0] slot_reg, slot_next;
  logic [CORE_NO_WIDTH-1:0] core_reg, core_next;
  logic [CORE_NO_WIDTH-1:0] dcore_reg, dcore_next;
  logic [SLOT_NO_WIDTH-1:0] dslot_reg, dslot_next;
  logic [CORE_NO_WIDTH-1:0] err_core_reg, err_core_next;
  logic                     en_reg;
  logic                     init_error_reg;
  logic                     rx_abort_reg;

  logic                     wr_start;
  logic                     wr_busy;
  logic                     wr_issued;
  logic                     wr_done;
  logic                     wr_err;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]    ctrl_data;
  logic                     unused_bits;

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
    assign ctrl_data[gi*8 +: 8] = CTRL_BYTE;
  end

  // Address is formed from the core index that will be current after this edge.
  assign wr_addr = (ADDR_WIDTH'(core_next) << CORE_ADDR_LSB) | CTRL_OFFSET;

`ifdef CORE_BOOT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_reg, tmo_next;
`endif

  always_comb begin
    state_next    = state_reg;
    dly_next      = dly_reg;
    slot_next     = slot_reg;
    core_next     = core_reg;
    dcore_next    = dcore_reg;
    dslot_next    = dslot_reg;
    err_core_next = err_core_reg;
    wr_start      = 1'b0;
    case (state_reg)
      WAIT_DLY: begin
        dly_next = dly_reg + 1'b1;
        if (dly_reg == LAST_DLY) begin
          dly_next   = '0;
          state_next = SLOT_PROG;
        end
      end
      SLOT_PROG: begin
        slot_next = slot_reg + 1'b1;
        if (slot_reg == LAST_SLOT) begin
          core_next  = '0;
          wr_start   = 1'b1;
          state_next = CORE_WR;
        end
      end
      CORE_WR: begin
        if (wr_issued) state_next = CORE_RESP;
      end
      CORE_RESP: begin
        if (wr_done) begin
          if (wr_err) begin
            err_core_next = core_reg;
            state_next    = ERROR;
          end else if (core_reg == LAST_CORE) begin
            dcore_next = '0;
            dslot_next = '0;
            state_next = DESC_INJ;
          end else begin
            core_next  = core_reg + 1'b1;
            wr_start   = 1'b1;
            state_next = CORE_WR;
          end
        end
      end
      DESC_INJ: begin
        // Core index is the fast-moving field of the descriptor sweep.
        if (inject_rx_desc_ready) begin
          dcore_next = dcore_reg + 1'b1;
          if (dcore_reg == LAST_CORE) begin
            dslot_next = dslot_reg + 1'b1;
            if (dslot_reg == LAST_SLOT) state_next = RUN;
          end
        end
      end
      RUN, ERROR: begin
        if (init_req) begin
          slot_next     = '0;
          core_next     = '0;
          err_core_next = '0;
          state_next    = SLOT_PROG;
        end
      end
      default: state_next = WAIT_DLY;
    endcase
`ifdef CORE_BOOT_TIMEOUT_EN
    // The write engine keeps any pending valid until its handshake even after we give up.
    tmo_next = tmo_reg;
    if (wr_start) begin
      tmo_next = '0;
    end else if (state_reg == CORE_WR || state_reg == CORE_RESP) begin
      tmo_next = tmo_reg + 1'b1;
      if (tmo_reg == LAST_TMO && !(state_reg == CORE_RESP && wr_done)) begin
        err_core_next = core_reg;
        state_next    = ERROR;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= WAIT_DLY;
      dly_reg        <= '0;
      slot_reg       <= '0;
      core_reg       <= '0;
      dcore_reg      <= '0;
      dslot_reg      <= '0;
      err_core_reg   <= '0;
      en_reg         <= 1'b0;
      init_error_reg <= 1'b0;
      rx_abort_reg   <= 1'b1;
    end else begin
      state_reg      <= state_next;
      dly_reg        <= dly_next;
      slot_reg       <= slot_next;
      core_reg       <= core_next;
      dcore_reg      <= dcore_next;
      dslot_reg      <= dslot_next;
      err_core_reg   <= err_core_next;
      en_reg         <= (state_next == RUN);
      init_error_reg <= (state_next == ERROR);
      rx_abort_reg   <= (state_next != RUN);
    end
  end

`ifdef CORE_BOOT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_reg <= '0;
    else        tmo_reg <= tmo_next;
  end
`endif

  core_boot_axi_wr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_axi_wr (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (wr_start),
    .addr          (wr_addr),
    .data          (ctrl_data),
    .strb          (STRB_ALL[STRB_WIDTH-1:0]),
    .busy          (wr_busy),
    .issued        (wr_issued),
    .done          (wr_done),
    .err           (wr_err),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid)
  );

  assign m_axi_awid    = '0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = 1'b1;

  assign slot_addr_wr_valid = (state_reg == SLOT_PROG);
  assign slot_addr_wr_no    = slot_reg;
  assign slot_addr_wr_data  = FIRST_SLOT_ADDR + SLOT_ADDR_EFF'(slot_reg) * SLOT_ADDR_STEP;

  assign inject_rx_desc       = {dcore_reg, dslot_reg};
  assign inject_rx_desc_valid = (state_reg == DESC_INJ);

  assign tx_enable  = en_reg;
  assign rx_enable  = en_reg;
  assign init_done  = en_reg;
  assign init_error = init_error_reg;
  assign rx_abort   = rx_abort_reg;
  assign err_core   = err_core_reg;

  assign unused_bits = ^{m_axi_bid, wr_busy};

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Scoreboard bench for core_boot_ctrl: expected slot writes, AXI addresses and
// descriptors are queued by the stimulus and popped by independent monitors.
module tb_core_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0;
  logic [7:0]  awid;
  logic [18:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [7:0]  bid = 8'd0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [3:0]  slot_no;
  logic [6:0]  slot_data;
  logic        slot_vld;
  logic [6:0]  desc;
  logic        desc_vld;
  logic        desc_ready = 1'b0;
  logic        tx_enable, rx_enable, rx_abort, init_done, init_error;
  logic [2:0]  err_core;

  core_boot_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .init_req             (init_req),
    .m_axi_awid           (awid),
    .m_axi_awaddr         (awaddr),
    .m_axi_awlen          (awlen),
    .m_axi_awsize         (awsize),
    .m_axi_awburst        (awburst),
    .m_axi_awvalid        (awvalid),
    .m_axi_awready        (awready),
    .m_axi_wdata          (wdata),
    .m_axi_wstrb          (wstrb),
    .m_axi_wlast          (wlast),
    .m_axi_wvalid         (wvalid),
    .m_axi_wready         (wready),
    .m_axi_bid            (bid),
    .m_axi_bresp          (bresp),
    .m_axi_bvalid         (bvalid),
    .m_axi_bready         (bready),
    .slot_addr_wr_no      (slot_no),
    .slot_addr_wr_data    (slot_data),
    .slot_addr_wr_valid   (slot_vld),
    .inject_rx_desc       (desc),
    .inject_rx_desc_valid (desc_vld),
    .inject_rx_desc_ready (desc_ready),
    .tx_enable            (tx_enable),
    .rx_enable            (rx_enable),
    .rx_abort             (rx_abort),
    .init_done            (init_done),
    .init_error           (init_error),
    .err_core             (err_core)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q_slot[$];
  logic [63:0] q_aw[$];
  logic [63:0] q_desc[$];

  // Slave behaviour knobs, written by the stimulus only.
  int aw_delay    = 0;
  int w_delay     = 0;
  int err_sel     = -1;
  bit desc_toggle = 1'b0;

  // Monitor-owned state.
  int       aw_cnt = 0, w_cnt = 0, aw_wait = 0, w_wait = 0;
  bit       aw_got = 0, w_got = 0, b_pend = 0;
  logic [2:0] b_core = 3'd0;
  bit       held = 0;
  logic [6:0] held_val = 7'd0;

  task automatic eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_slots();
    for (int i = 0; i < 16; i++) q_slot.push_back(64'(i * 256 + ((64 + 4 * i) % 128)));
  endtask

  task automatic push_aw(input int ncores);
    for (int c = 0; c < ncores; c++) q_aw.push_back(64'((c << 16) | 'hFFF8));
  endtask

  task automatic push_desc();
    for (int s = 0; s < 16; s++)
      for (int c = 0; c < 8; c++) q_desc.push_back(64'(c * 16 + s));
  endtask

  // Slot programming monitor
  always @(negedge clk) begin : slot_mon
    logic [63:0] e;
    if (rst_n && slot_vld) begin
      $display("[TB] slot %0d data 0x%0h", slot_no, slot_data);
      if (q_slot.size() == 0) begin
        eq("slot_unexpected", {52'd0, slot_no, 1'b0, slot_data}, 64'hDEAD);
      end else begin
        e = q_slot.pop_front();
        eq("slot_write", {52'd0, slot_no, 1'b0, slot_data}, e);
      end
    end
  end

  // AXI write slave: ready decided here, handshake lands on the next posedge
  always @(negedge clk) begin : axi_slave
    logic [63:0] e;
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_pend = 0;
    end else begin
      bvalid = 1'b0;
      if (b_pend) begin
        bvalid = 1'b1;
        bresp  = (int'(b_core) == err_sel) ? 2'b10 : 2'b00;
        b_pend = 1'b0;
        eq("bready", 64'(bready), 64'd1);
        $display("[TB] B core %0d resp %0d", b_core, bresp);
      end
      awready = 1'b0;
      if (awvalid) begin
        if (aw_wait >= aw_delay) begin
          awready = 1'b1; aw_wait = 0; aw_cnt++; aw_got = 1'b1; b_core = awaddr[18:16];
          $display("[TB] AW addr 0x%05h", awaddr);
          eq("aw_fixed", {awid, awlen, 1'b0, awsize, 2'b0, awburst}, {8'd0, 8'd0, 4'd3, 4'd1});
          if (q_aw.size() == 0) eq("aw_unexpected", 64'(awaddr), 64'hDEAD);
          else begin
            e = q_aw.pop_front();
            eq("aw_addr", 64'(awaddr), e);
          end
        end else aw_wait++;
      end
      wready = 1'b0;
      if (wvalid) begin
        if (w_wait >= w_delay) begin
          wready = 1'b1; w_wait = 0; w_cnt++; w_got = 1'b1;
          $display("[TB] W data 0x%0h strb 0x%0h", wdata, wstrb);
          eq("w_beat", {wdata[55:0], wstrb}, 64'h80);
          eq("w_top_last", {wdata[63:56], 7'd0, wlast}, 64'h1);
        end else w_wait++;
      end
      if (aw_got && w_got) begin
        b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0;
      end
    end
  end

  // Descriptor monitor: checks order on handshake and stability while stalled
  always @(negedge clk) begin : desc_mon
    logic [63:0] e;
    if (!rst_n) begin
      desc_ready = 1'b0; held = 1'b0;
    end else begin
      if (held) begin
        eq("desc_hold", {56'd0, desc_vld, desc}, {56'd0, 1'b1, held_val});
        held = 1'b0;
      end
      desc_ready = desc_toggle ? ~desc_ready : 1'b1;
      if (desc_vld) begin
        if (desc_ready) begin
          $display("[TB] desc core %0d slot %0d", desc[6:4], desc[3:0]);
          if (q_desc.size() == 0) eq("desc_unexpected", 64'(desc), 64'hDEAD);
          else begin
            e = q_desc.pop_front();
            eq("desc", 64'(desc), e);
          end
        end else begin
          held = 1'b1; held_val = desc;
        end
      end
    end
  end

  task automatic measure_delay();
    int i;
    for (i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (slot_vld) break;
    end
    eq("start_delay", 64'(i), 64'd1000);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (init_done) break;
    end
    eq("done_timeout", 64'(i < 5000), 64'd1);
  endtask

  task automatic check_run();
    eq("run_outputs", {59'd0, tx_enable, rx_enable, init_done, rx_abort, init_error}, 64'b11100);
  endtask

  task automatic check_empty(input string name);
    eq(name, 64'(q_slot.size() + q_aw.size() + q_desc.size()), 64'd0);
  endtask

  task automatic rerun();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  initial begin
    int a0, w0, i;
    // Reset state
    repeat (5) @(negedge clk);
    eq("rst_valids", {59'd0, awvalid, wvalid, slot_vld, desc_vld, tx_enable}, 64'd0);
    eq("rst_status", {56'd0, rx_abort, rx_enable, init_done, init_error, 1'b0, err_core}, 64'h80);
    eq("rst_axi_fixed", {40'd0, awid, awlen, awsize, awburst, wlast, bready}, {40'd0, 8'd0, 8'd0, 3'd3, 2'd1, 1'b1, 1'b1});

    // 1: defaults, slave always ready
    push_slots(); push_aw(8); push_desc();
    rst_n = 1'b1;
    measure_delay();
    wait_done();
    check_run();
    check_empty("t1_queues");

    // 2: delayed awready, then delayed wready
    aw_delay = 3; w_delay = 0;
    a0 = aw_cnt; w0 = w_cnt;
    push_slots(); push_aw(8); push_desc();
    rerun(); wait_done(); check_run();
    eq("t2a_beats", 64'((aw_cnt - a0) * 16 + (w_cnt - w0)), 64'(8 * 16 + 8));
    check_empty("t2a_queues");
    aw_delay = 0; w_delay = 3;
    a0 = aw_cnt; w0 = w_cnt;
    push_slots(); push_aw(8); push_desc();
    rerun(); wait_done(); check_run();
    eq("t2b_beats", 64'((aw_cnt - a0) * 16 + (w_cnt - w0)), 64'(8 * 16 + 8));
    check_empty("t2b_queues");
    w_delay = 0;

    // 3: descriptor ready toggling
    desc_toggle = 1'b1;
    push_slots(); push_aw(8); push_desc();
    rerun(); wait_done(); check_run();
    check_empty("t3_queues");
    desc_toggle = 1'b0;

    // 4: SLVERR on core 5, then recovery
    err_sel = 5;
    push_slots(); push_aw(6);
    rerun();
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (init_error) break;
    end
    eq("err_timeout", 64'(i < 3000), 64'd1);
    eq("err_core", 64'(err_core), 64'd5);
    eq("err_outputs", {59'd0, tx_enable, rx_enable, init_done, rx_abort, init_error}, 64'b00011);
    repeat (20) @(negedge clk);
    eq("err_hold", {62'd0, init_error, desc_vld}, 64'b10);
    check_empty("t4_queues");
    err_sel = -1;
    push_slots(); push_aw(8); push_desc();
    rerun(); wait_done(); check_run();
    eq("err_core_clr", 64'(err_core), 64'd0);
    check_empty("t4b_queues");

    // 5: async reset while core 3 AW is pending
    aw_delay = 8;
    push_slots(); push_aw(3);
    rerun();
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (awvalid && awaddr[18:16] == 3'd3) break;
    end
    eq("core3_seen", 64'(i < 3000), 64'd1);
    rst_n = 1'b0;
    #1;
    eq("rst_awvalid_drop", {61'd0, awvalid, wvalid, rx_abort}, 64'b001);
    repeat (3) @(negedge clk);
    aw_delay = 0;
    check_empty("t5_pre_queues");
    push_slots(); push_aw(8); push_desc();
    rst_n = 1'b1;
    measure_delay();
    wait_done();
    check_run();
    check_empty("t5_queues");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
